ct_ifu_icache_data_array_param: RTL and testbench
=================================================

Name: ct_ifu_icache_data_array_param

Overview:
- Parametrised successor to the fixed 4-bank x 32-bit IFU icache data array.
- Generalised in bank count, bank width, depth and read latency.
- Adds a request/ready handshake, a hardware init sweep state machine that zero-fills every entry, per-bank read-valid tracking, and optional per-bank parity.
- Sits between the IFU icache control (refill/fetch) and the data-path pre-decode; one single-port behavioural SRAM per bank.

Parameters:
NUM_BANKS, 4, number of independent data banks (1..8)
BANK_WIDTH, 32, data bits per bank
INDEX_WIDTH, 11, address bits per bank; DEPTH = 2**INDEX_WIDTH entries
READ_LAT, 1, read latency in cycles: 1 = SRAM output, 2 = extra output register

Ports:
forever_cpuclk  in  1  free-running core clock
cpurst  in  1  synchronous active-high reset
req_vld  in  1  access request valid
req_rdy  out  1  array can accept a request this cycle
req_wen  in  1  1 = write, 0 = read
req_index  in  INDEX_WIDTH  entry index
req_bank_en  in  NUM_BANKS  per-bank enable; bit 0 = bank0
req_wdata  in  NUM_BANKS*BANK_WIDTH  write data; bank0 in MSBs
init_req  in  1  start a zero-fill sweep
init_busy  out  1  sweep in progress
init_done  out  1  one-cycle pulse when the sweep completes
rd_vld  out  1  read data valid
rd_bank_vld  out  NUM_BANKS  banks that supplied rd_data
rd_data  out  NUM_BANKS*BANK_WIDTH  read data; bank0 in MSBs; disabled banks drive 0
parity_err  out  NUM_BANKS  per-bank parity error, qualified by rd_vld

Behaviour:
- One clock (forever_cpuclk). Synchronous active-high reset (cpurst). All state is updated on the rising edge.
- State machine: INIT, IDLE.
- While cpurst = 1:
  - state = INIT, sweep counter = 0.
  - init_busy = 1, req_rdy = 0, init_done = 0.
  - rd_vld = 0, rd_bank_vld = 0, rd_data = 0, parity_err = 0.
- INIT state:
  - Each cycle writes zero (and even parity) to all banks at the sweep counter, then increments the counter.
  - The first write occurs in the first cycle after cpurst falls. The sweep takes exactly DEPTH cycles.
  - After the write at DEPTH-1: go to IDLE; init_busy falls and init_done pulses high for one cycle in that same first IDLE cycle.
  - The counter is INDEX_WIDTH+1 bits wide; it does not wrap during a sweep.
- IDLE state:
  - req_rdy = 1.
  - A request is accepted when req_vld & req_rdy.
  - If init_req = 1 in IDLE: go to INIT with counter = 0 and req_rdy = 0 in that cycle. init_req wins over a simultaneous req_vld, and that request is not accepted.
  - init_req while in INIT is ignored.
  - cpurst during a sweep restarts it from index 0.
- Write (req_wen = 1):
  - Writes req_wdata slices into the enabled banks at req_index.
  - No read response is produced.
- Read (req_wen = 0):
  - Reads the enabled banks.
  - rd_vld, rd_bank_vld = req_bank_en, and rd_data are valid exactly READ_LAT cycles after acceptance.
  - If req_bank_en = 0, the read is accepted, but rd_vld stays 0.
  - rd_vld/rd_bank_vld/rd_data return to 0 in every cycle without a completing read.
- Single-port: one access per cycle, back-to-back accepted every cycle.
- Read after write:
  - Reading index X in the cycle after writing X returns the new data.
  - A read accepted before init_req completes normally with pre-sweep data.
- Reset does not clear SRAM contents; only the sweep does.

Optional Feature:
- Macro ICACHE_DATA_PARITY_EN.
- Defined:
  - Each bank entry stores BANK_WIDTH+1 bits: data plus an even-parity bit generated on write (and on sweep writes).
  - On read, parity_err[b] = 1 when rd_bank_vld[b] = 1 and the recomputed parity mismatches the stored bit. It is timed with rd_vld.
  - A test-only input is not added; parity corruption is done by the bench via hierarchical force on the stored bit.
- Undefined:
  - No parity storage.
  - parity_err is tied to 0.

Test Plan:
- Reset/sweep: hold cpurst 3 cycles, release → init_busy = 1 and req_rdy = 0 for 2048 cycles; init_done pulses on cycle 2048 after release; then read index 0x7FF on all banks → rd_data = 0 at READ_LAT.
- Write/read: write index 0x123, bank_en = 4'b1111, wdata = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D; read it the next cycle → rd_vld at +READ_LAT with identical data and rd_bank_vld = 4'b1111.
- Partial banks: write bank_en = 4'b0101 to index 0x10 with data 0xFFFFFFFF per slice; read with bank_en = 4'b0111 → bank0 and bank2 = 0xFFFFFFFF, bank1 = 0, bank3 = 0 (disabled), rd_bank_vld = 4'b0111.
- Init priority: in IDLE, assert req_vld (read 0x123) and init_req in the same cycle → request not accepted, no rd_vld, a new 2048-cycle sweep runs; a mid-sweep cpurst pulse restarts the sweep, with init_done 2048 cycles after release.
- Back-to-back: READ_LAT = 2, reads of index 1, 2 and 3 in consecutive cycles → three consecutive rd_vld cycles in order, then rd_vld = 0.
- ICACHE_DATA_PARITY_EN: write 0xA5A5A5A5 to bank2 at index 5, force-flip its stored parity bit, read → parity_err = 4'b0100 with rd_vld; without the macro, parity_err = 0.

Source files
------------

// File: rtl/ct_ifu_icache_data_array_param_if.sv
// Request/response bundle between the IFU icache control and the data array.
// master = control side (issues requests), slave = data array.
interface ct_ifu_icache_data_array_param_if #(
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned BANK_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 11
);

  localparam int unsigned DATA_W = NUM_BANKS * BANK_WIDTH;

  // Access request channel
  logic                   req_vld;
  logic                   req_rdy;
  logic                   req_wen;
  logic [INDEX_WIDTH-1:0] req_index;
  logic [NUM_BANKS-1:0]   req_bank_en;
  logic [DATA_W-1:0]      req_wdata;

  // Zero-fill sweep control/status
  logic                   init_req;
  logic                   init_busy;
  logic                   init_done;

  // Read response channel
  logic                   rd_vld;
  logic [NUM_BANKS-1:0]   rd_bank_vld;
  logic [DATA_W-1:0]      rd_data;
  logic [NUM_BANKS-1:0]   parity_err;

  modport master (
    output req_vld, req_wen, req_index, req_bank_en, req_wdata, init_req,
    input  req_rdy, init_busy, init_done, rd_vld, rd_bank_vld, rd_data, parity_err
  );

  modport slave (
    input  req_vld, req_wen, req_index, req_bank_en, req_wdata, init_req,
    output req_rdy, init_busy, init_done, rd_vld, rd_bank_vld, rd_data, parity_err
  );

endinterface

// File: rtl/ct_ifu_icache_data_array_param.sv
// Parametrised IFU icache data array: NUM_BANKS single-port banks sharing one
// index, request/ready handshake, hardware zero-fill sweep, READ_LAT of 1 or 2.
// Optional per-bank even parity is enabled by defining ICACHE_DATA_PARITY_EN.
module ct_ifu_icache_data_array_param #(
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned BANK_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 11,
  parameter int unsigned READ_LAT    = 1
) (
  input  logic                               forever_cpuclk,
  input  logic                               cpurst,
  ct_ifu_icache_data_array_param_if.slave    bus
);

  localparam int unsigned DEPTH  = 1 << INDEX_WIDTH;
  localparam int unsigned CNT_W  = INDEX_WIDTH + 1;
  localparam int unsigned DATA_W = NUM_BANKS * BANK_WIDTH;
`ifdef ICACHE_DATA_PARITY_EN
  localparam int unsigned PAR_W  = 1;
`else
  localparam int unsigned PAR_W  = 0;
`endif
  localparam int unsigned ENTRY_W = BANK_WIDTH + PAR_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;

  logic [0:0]             state_q;
  logic [0:0]             state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   init_done_q;
  logic                   init_done_d;
  logic                   req_rdy_c;
  logic                   sweep_we_c;
  logic                   acc_c;
  logic                   acc_wr_c;
  logic                   acc_rd_c;
  logic [INDEX_WIDTH-1:0] wr_idx_c;

  logic                   rd1_vld_q;
  logic [NUM_BANKS-1:0]   rd1_ben_q;
  logic [DATA_W-1:0]      rd1_data_c;
  logic [NUM_BANKS-1:0]   rd1_perr_c;

  // Next-state logic: INIT sweeps one entry per cycle, IDLE serves requests
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = 1'b0;
    req_rdy_c   = 1'b0;
    sweep_we_c  = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_we_c = ~cpurst;
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // A sweep request takes the cycle; any simultaneous access is refused
        if (bus.init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          req_rdy_c = ~cpurst;
        end
      end
    endcase
  end

  // State register; reset restarts the sweep from index 0
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign acc_c    = bus.req_vld & req_rdy_c;
  assign acc_wr_c = acc_c & bus.req_wen;
  assign acc_rd_c = acc_c & ~bus.req_wen;
  assign wr_idx_c = sweep_we_c ? cnt_q[INDEX_WIDTH-1:0] : bus.req_index;

  assign bus.req_rdy   = req_rdy_c;
  assign bus.init_busy = (state_q == ST_INIT);
  assign bus.init_done = init_done_q;

  // First read stage: which banks were read and whether any response is due
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      rd1_vld_q <= 1'b0;
      rd1_ben_q <= '0;
    end else begin
      rd1_vld_q <= acc_rd_c & (|bus.req_bank_en);
      rd1_ben_q <= acc_rd_c ? bus.req_bank_en : '0;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [ENTRY_W-1:0]    rd_word_q;
    logic [BANK_WIDTH-1:0] wr_slice_c;
    logic [ENTRY_W-1:0]    wr_word_c;
    logic                  wr_en_c;

    // Bank 0 occupies the most significant slice of the data bus
    assign wr_slice_c = sweep_we_c ? '0
                      : bus.req_wdata[(NUM_BANKS-1-b)*BANK_WIDTH +: BANK_WIDTH];
    assign wr_en_c    = sweep_we_c | (acc_wr_c & bus.req_bank_en[b]);

`ifdef ICACHE_DATA_PARITY_EN
    // Stored word carries an even-parity bit above the data
    assign wr_word_c     = {^wr_slice_c, wr_slice_c};
    assign rd1_perr_c[b] = rd1_ben_q[b] & (^rd_word_q);
`else
    assign wr_word_c     = wr_slice_c;
    assign rd1_perr_c[b] = 1'b0;
`endif

    // Single-port SRAM write; contents survive reset
    always_ff @(posedge forever_cpuclk) begin
      if (wr_en_c) begin
        mem[wr_idx_c] <= wr_word_c;
      end
    end

    // SRAM read port; disabled banks return zero
    always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
        rd_word_q <= '0;
      end else if (acc_rd_c && bus.req_bank_en[b]) begin
        rd_word_q <= mem[bus.req_index];
      end else begin
        rd_word_q <= '0;
      end
    end

    assign rd1_data_c[(NUM_BANKS-1-b)*BANK_WIDTH +: BANK_WIDTH] = rd_word_q[BANK_WIDTH-1:0];
  end

  if (READ_LAT == 1) begin : g_lat1
    assign bus.rd_vld      = rd1_vld_q;
    assign bus.rd_bank_vld = rd1_ben_q;
    assign bus.rd_data     = rd1_data_c;
    assign bus.parity_err  = rd1_perr_c;
  end else begin : g_lat2
    logic                 rd2_vld_q;
    logic [NUM_BANKS-1:0] rd2_ben_q;
    logic [DATA_W-1:0]    rd2_data_q;
    logic [NUM_BANKS-1:0] rd2_perr_q;

    // Extra output register stage for timing-constrained pre-decode paths
    always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
        rd2_vld_q  <= 1'b0;
        rd2_ben_q  <= '0;
        rd2_data_q <= '0;
        rd2_perr_q <= '0;
      end else begin
        rd2_vld_q  <= rd1_vld_q;
        rd2_ben_q  <= rd1_ben_q;
        rd2_data_q <= rd1_data_c;
        rd2_perr_q <= rd1_perr_c;
      end
    end

    assign bus.rd_vld      = rd2_vld_q;
    assign bus.rd_bank_vld = rd2_ben_q;
    assign bus.rd_data     = rd2_data_q;
    assign bus.parity_err  = rd2_perr_q;
  end

endmodule

// File: tb/tb_ct_ifu_icache_data_array_param.sv
// Scoreboard bench for ct_ifu_icache_data_array_param (READ_LAT = 2).
// Parity checks are compiled in when ICACHE_DATA_PARITY_EN is defined.
module tb_ct_ifu_icache_data_array_param;

  localparam int unsigned NB    = 4;
  localparam int unsigned BW    = 32;
  localparam int unsigned IW    = 11;
  localparam int unsigned RL    = 2;
  localparam int unsigned DEPTH = 1 << IW;
  localparam int unsigned DW    = NB * BW;

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] data;
    logic [NB-1:0] ben;
    logic [NB-1:0] perr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  bit          mon_en = 1'b0;
  logic [NB-1:0] perr_inj = '0;

  logic [BW-1:0] mdl [NB][DEPTH];
  exp_t          sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ct_ifu_icache_data_array_param_if #(.NUM_BANKS(NB), .BANK_WIDTH(BW), .INDEX_WIDTH(IW)) bus ();

  ct_ifu_icache_data_array_param #(
    .NUM_BANKS(NB), .BANK_WIDTH(BW), .INDEX_WIDTH(IW), .READ_LAT(RL)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst         (rst),
    .bus            (bus)
  );

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_zero();
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < DEPTH; i++)
        mdl[b][i] = '0;
  endfunction

  // Monitor: pops the scoreboard whenever a read response appears
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.rd_vld === 1'b1) begin
        if (sb.size() == 0) begin
          chk("rd_vld_spurious", 256'(bus.rd_vld), 256'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rd_cycle", 256'(cyc), 256'(e.cyc));
          chk("rd_data", 256'(bus.rd_data), 256'(e.data));
          chk("rd_bank_vld", 256'(bus.rd_bank_vld), 256'(e.ben));
          chk("parity_err", 256'(bus.parity_err), 256'(e.perr));
        end
      end else begin
        chk("idle_outputs", 256'({bus.rd_vld, bus.rd_bank_vld, bus.parity_err, bus.rd_data}), 256'(0));
        if (sb.size() != 0 && sb[0].cyc <= cyc) begin
          chk("rd_vld_missing", 256'(bus.rd_vld), 256'(1));
          sb.delete(0);
        end
      end
    end
  end

  // One handshake cycle; model updated at the accepting edge
  task automatic access(input logic v, input logic w, input logic [IW-1:0] idx,
                        input logic [NB-1:0] ben, input logic [DW-1:0] wd);
    int unsigned now;
    exp_t e;
    bus.req_vld = v; bus.req_wen = w; bus.req_index = idx;
    bus.req_bank_en = ben; bus.req_wdata = wd; bus.init_req = 1'b0;
    @(negedge clk);
    chk("req_rdy", 256'(bus.req_rdy), 256'(1));
    now = cyc;
    @(posedge clk);
    if (v) begin
      if (w) begin
        for (int b = 0; b < NB; b++)
          if (ben[b]) mdl[b][idx] = wd[(NB-1-b)*BW +: BW];
      end else if (ben != '0) begin
        e.cyc  = now + RL;
        e.ben  = ben;
        e.perr = perr_inj;
        e.data = '0;
        for (int b = 0; b < NB; b++)
          if (ben[b]) e.data[(NB-1-b)*BW +: BW] = mdl[b][idx];
        sb.push_back(e);
      end
    end
    #1;
    bus.req_vld = 1'b0;
  endtask

  // Sweep window: busy, not ready, no done; optionally the completion pulse
  task automatic sweep_check(input int unsigned ncyc, input bit expect_done, input bit poke);
    for (int i = 0; i < ncyc; i++) begin
      if (poke && i < 1000) begin
        bus.init_req = 1'($urandom_range(0, 1));
        bus.req_vld  = 1'($urandom_range(0, 1));
        bus.req_wen  = 1'($urandom_range(0, 1));
        bus.req_bank_en = 4'hF;
      end else begin
        bus.init_req = 1'b0;
        bus.req_vld  = 1'b0;
      end
      @(negedge clk);
      chk("sweep_flags", 256'({bus.init_busy, bus.req_rdy, bus.init_done}), 256'(3'b100));
      @(posedge clk); #1;
    end
    bus.init_req = 1'b0;
    bus.req_vld  = 1'b0;
    if (expect_done) begin
      @(negedge clk);
      chk("sweep_done", 256'({bus.init_busy, bus.req_rdy, bus.init_done}), 256'(3'b011));
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_done", 256'({bus.init_busy, bus.req_rdy, bus.init_done}), 256'(3'b010));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset(input int unsigned n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
      chk("rst_flags", 256'({bus.init_busy, bus.req_rdy, bus.init_done}), 256'(3'b100));
    end
    rst = 1'b0;
    model_zero();
  endtask

  // Read and sweep request together: sweep wins, read refused
  task automatic init_with_read();
    bus.req_vld = 1'b1; bus.req_wen = 1'b0; bus.req_index = 11'h123;
    bus.req_bank_en = 4'hF; bus.init_req = 1'b1;
    @(negedge clk);
    chk("init_req_flags", 256'({bus.init_busy, bus.req_rdy, bus.init_done}), 256'(3'b000));
    @(posedge clk); #1;
    bus.req_vld = 1'b0; bus.init_req = 1'b0;
    model_zero();
  endtask

  initial begin
    logic [DW-1:0] wd;
    rst = 1'b1;
    bus.req_vld = 1'b0; bus.req_wen = 1'b0; bus.req_index = '0;
    bus.req_bank_en = '0; bus.req_wdata = '0; bus.init_req = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    do_reset(3);
    sweep_check(DEPTH, 1'b1, 1'b0);

    access(1'b1, 1'b0, 11'h7FF, 4'hF, '0);
    access(1'b0, 1'b0, '0, '0, '0);

    wd = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    access(1'b1, 1'b1, 11'h123, 4'hF, wd);
    access(1'b1, 1'b0, 11'h123, 4'hF, '0);

    access(1'b1, 1'b1, 11'h010, 4'b0101, {NB{32'hFFFFFFFF}});
    access(1'b1, 1'b0, 11'h010, 4'b0111, '0);

    access(1'b1, 1'b0, 11'h001, 4'hF, '0);
    access(1'b1, 1'b0, 11'h002, 4'hF, '0);
    access(1'b1, 1'b0, 11'h003, 4'hF, '0);
    access(1'b1, 1'b0, 11'h004, 4'h0, '0);
    repeat (3) access(1'b0, 1'b0, '0, '0, '0);

    for (int i = 0; i < 400; i++) begin
      wd = {$urandom, $urandom, $urandom, $urandom};
      access(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             IW'($urandom_range(0, 31)), NB'($urandom), wd);
    end

    // Read accepted just before the sweep returns pre-sweep data
    access(1'b1, 1'b0, 11'h123, 4'hF, '0);
    init_with_read();
    sweep_check(DEPTH, 1'b1, 1'b1);
    access(1'b1, 1'b0, 11'h123, 4'hF, '0);
    access(1'b1, 1'b0, 11'h010, 4'hF, '0);

    // Mid-sweep reset restarts the sweep
    bus.init_req = 1'b1;
    @(posedge clk); #1;
    bus.init_req = 1'b0;
    model_zero();
    sweep_check(700, 1'b0, 1'b0);
    do_reset(2);
    sweep_check(DEPTH, 1'b1, 1'b0);

    wd = DW'(32'hA5A5A5A5) << ((NB - 1 - 2) * BW);
    access(1'b1, 1'b1, 11'h005, 4'b0100, wd);
`ifdef ICACHE_DATA_PARITY_EN
    dut.g_bank[2].mem[5][BW] = ~dut.g_bank[2].mem[5][BW];
    perr_inj = 4'b0100;
`endif
    access(1'b1, 1'b0, 11'h005, 4'b0100, '0);
    perr_inj = '0;
    access(1'b1, 1'b0, 11'h005, 4'b0001, '0);

    for (int i = 0; i < 300; i++) begin
      wd = {$urandom, $urandom, $urandom, $urandom};
      access(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             IW'($urandom_range(16, 47)), NB'($urandom), wd);
    end

    repeat (RL + 3) access(1'b0, 1'b0, '0, '0, '0);
    chk("scoreboard_drained", 256'(sb.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
